fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the CU. It reads 16-bit words from program memory at a 10-bit PC and presents instruction, imm and pc to the CU with a valid/ready handshake. It fetches a trailing immediate word when the instruction requires one. It redirects the PC to the CU's pc_out when the CU reports a taken branch.

Parameters:
RESET_PC, 10'h000, PC value loaded on reset
ADDR_W, 10, PC / memory address width
DATA_W, 16, instruction / immediate word width
IMM_BIT, 9, instruction bit that, when 1, marks a following immediate word

Ports:
clk  input  1  system clock, all logic on rising edge
rst_b  input  1  one clock; reset is synchronous and active-high
mem_addr  output  ADDR_W  program memory word address
mem_rd  output  1  read request; mem_addr held stable while high
mem_rdata  input  DATA_W  read data, valid when mem_valid=1
mem_valid  input  1  memory read completes this cycle
instruction  output  DATA_W  fetched instruction word to CU
imm  output  DATA_W  immediate word; 16'h0000 when none
pc  output  ADDR_W  address of the presented instruction word
instr_valid  output  1  instruction/imm/pc valid for the CU
cu_ready  input  1  CU accepts the presented instruction (handshake)
branch  input  1  CU: redirect PC; sampled only on handshake
pc_out  input  ADDR_W  CU branch target

Behaviour:
- Reset (rst_b=1 at a rising edge): state=FETCH_I, fetch_pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, instruction=0, imm=0, pc=RESET_PC, instr_valid=0. Reset overrides everything, including mid-fetch and mid-handshake. A mem_valid in the reset cycle is ignored.
- States: FETCH_I, FETCH_M, PRESENT.
- FETCH_I: mem_rd=1, mem_addr=fetch_pc.
  - On an edge with mem_valid=1: instruction<=mem_rdata, pc<=fetch_pc.
  - If mem_rdata[IMM_BIT]=1: go to FETCH_M, mem_addr<=fetch_pc+1 (mod 2^ADDR_W).
  - Else: imm<=0, go to PRESENT.
- FETCH_M: mem_rd=1. On mem_valid=1: imm<=mem_rdata, go to PRESENT.
- PRESENT: mem_rd=0, instr_valid=1. instruction, imm and pc hold stable until handshake.
- Handshake is an edge with instr_valid=1 and cu_ready=1. On handshake:
  - instr_valid<=0, go to FETCH_I.
  - fetch_pc <= branch ? pc_out : pc + (imm-flag ? 2 : 1), mod 2^ADDR_W.
- branch and pc_out are ignored outside the handshake edge.
- mem_valid is ignored whenever mem_rd=0.
- Wait states: mem_valid may stay low any number of cycles. The FSM holds with mem_rd and mem_addr stable.
- Latency, zero-wait memory (mem_valid=1 in the same cycle as mem_rd):
  - No-imm instruction: instr_valid high 1 cycle after fetch start.
  - Imm instruction: instr_valid high 2 cycles after fetch start.
  - Best-case throughput: one instruction per 2 cycles.
- Wrap-around: PC arithmetic is modulo 1024.
  - An instruction at 10'h3FF with imm takes its imm from 10'h000; the next pc is 10'h001.
  - A no-imm instruction at 10'h3FF is followed by pc 10'h000.
- cu_ready while instr_valid=0 has no effect.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W;
  - the IMM_BIT position;
  - the fetch state encoding (FETCH_I=2'd0, FETCH_M=2'd1, PRESENT=2'd2);
  - RESET_PC default.
- No sub-module; a single FSM plus the PC register.

Test Plan:
1. Reset then sequential fetch. Memory holds 0x4834 @0 and 0x6C12 @1, zero-wait, cu_ready=1.
   -> instr_valid with instruction=0x4834, pc=0, imm=0; then instruction=0x6C12, pc=1.
2. Immediate fetch. 0x0212 @5 (bit9=1) and 0x00A5 @6.
   -> instruction=0x0212, imm=0x00A5, pc=5; next fetch address is 7.
3. Branch. Present 0x9012 @3 with cu_ready=1, branch=1, pc_out=0x100.
   -> next mem_addr=0x100. branch=1 while instr_valid=0 does not change mem_addr.
4. Wait states and backpressure. mem_valid low for 3 cycles.
   -> mem_rd and mem_addr hold, instr_valid stays 0.
   Then cu_ready low for 4 cycles -> instruction, imm and pc stable throughout.
5. Wrap-around. Instruction with imm @0x3FF, imm @0x000.
   -> imm read from addr 0; next pc=0x001. A no-imm instruction @0x3FF is followed by pc=0x000.
6. Reset mid-operation. Assert rst_b during FETCH_M, with mem_valid=1 in that cycle.
   -> next cycle: instr_valid=0, mem_addr=RESET_PC, imm=0, and no data captured.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: shared widths, immediate-flag position and fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int IMM_BIT = 9;

  localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;

  typedef enum logic [1:0] {
    FETCH_I = 2'd0,
    FETCH_M = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: reads instruction (+ optional trailing immediate) words from program
// memory and presents them to the CU over a valid/ready handshake.
module fetch_unit #(
  parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int                         ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                         DATA_W   = cpu_pkg::DATA_W,
  parameter int                         IMM_BIT  = cpu_pkg::IMM_BIT
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  input  logic              cu_ready,
  input  logic              branch,
  input  logic [ADDR_W-1:0] pc_out
);
  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] seq_pc;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= FETCH_I;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_q       <= 1'b0;
      instr_q    <= '0;
      imm_q      <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Sequential successor skips the immediate word when the presented instruction has one.
  assign seq_pc = pc_q + (instr_q[IMM_BIT] ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    unique case (state_q)
      FETCH_I: begin
        // Only reachable with rd_q low straight after reset.
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = fetch_pc_q;
        end else if (mem_valid) begin
          instr_d = mem_rdata;
          pc_d    = fetch_pc_q;
          if (mem_rdata[IMM_BIT]) begin
            state_d = FETCH_M;
            addr_d  = fetch_pc_q + ADDR_W'(1);
          end else begin
            imm_d   = '0;
            state_d = PRESENT;
            rd_d    = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      FETCH_M: begin
        if (mem_valid) begin
          imm_d   = mem_rdata;
          state_d = PRESENT;
          rd_d    = 1'b0;
          valid_d = 1'b1;
        end
      end
      PRESENT: begin
        if (cu_ready) begin
          fetch_pc_d = branch ? pc_out : seq_pc;
          addr_d     = fetch_pc_d;
          rd_d       = 1'b1;
          valid_d    = 1'b0;
          state_d    = FETCH_I;
        end
      end
      default: state_d = FETCH_I;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign instruction = instr_q;
  assign imm         = imm_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed checks of fetch_unit against a behavioural program memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] instruction;
  logic [15:0] imm;
  logic [9:0]  pc;
  logic        instr_valid;
  logic        cu_ready;
  logic        branch;
  logic [9:0]  pc_out;
  logic        stall;

  logic [15:0] mem [0:1023];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_valid = mem_rd && !stall;

  fetch_unit dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instruction(instruction),
    .imm(imm), .pc(pc), .instr_valid(instr_valid), .cu_ready(cu_ready),
    .branch(branch), .pc_out(pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [9:0] addr);
    chk({tag, ".mem_rd"}, {31'd0, mem_rd}, 32'd1);
    chk({tag, ".mem_addr"}, {22'd0, mem_addr}, {22'd0, addr});
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic chk_present(input string tag, input logic [15:0] ins, input logic [15:0] im,
                             input logic [9:0] p);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, ".instr"}, {16'd0, instruction}, {16'd0, ins});
    chk({tag, ".imm"}, {16'd0, imm}, {16'd0, im});
    chk({tag, ".pc"}, {22'd0, pc}, {22'd0, p});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h000] = 16'h4834;
    mem[10'h001] = 16'h6C12;
    mem[10'h002] = 16'h1034;
    mem[10'h003] = 16'h9012;
    mem[10'h005] = 16'h0212;
    mem[10'h006] = 16'h00A5;
    mem[10'h007] = 16'h3C00;
    mem[10'h100] = 16'h4005;
    mem[10'h3FF] = 16'h0200;

    rst_b = 1'b1; cu_ready = 1'b0; branch = 1'b0; pc_out = '0; stall = 1'b0;
    tick(); tick();
    chk("rst.mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst.mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.instr", {16'd0, instruction}, 32'd0);
    chk("rst.imm", {16'd0, imm}, 32'd0);
    chk("rst.pc", {22'd0, pc}, 32'd0);

    // Sequential fetch
    rst_b = 1'b0;
    tick(); chk_fetch("seq0.fetch", 10'h000);
    tick(); chk_present("seq0", 16'h4834, 16'h0000, 10'h000);
    cu_ready = 1'b1;
    tick(); chk_fetch("seq1.fetch", 10'h001);
    tick(); chk_present("seq1", 16'h6C12, 16'h0000, 10'h001);
    tick(); chk_fetch("seq2.fetch", 10'h002);
    tick(); chk_present("seq2", 16'h1034, 16'h0000, 10'h002);
    tick(); chk_fetch("seq3.fetch", 10'h003);
    tick(); chk_present("br0", 16'h9012, 16'h0000, 10'h003);

    // Branch taken on handshake
    branch = 1'b1; pc_out = 10'h100; stall = 1'b1;
    tick(); chk_fetch("br.target", 10'h100);
    pc_out = 10'h200;
    tick(); chk_fetch("br.ignored_when_invalid", 10'h100);
    branch = 1'b0; stall = 1'b0;
    tick(); chk_present("br1", 16'h4005, 16'h0000, 10'h100);

    // Immediate fetch
    branch = 1'b1; pc_out = 10'h005;
    tick(); chk_fetch("imm.fetch_i", 10'h005);
    branch = 1'b0;
    tick(); chk_fetch("imm.fetch_m", 10'h006);
    tick(); chk_present("imm", 16'h0212, 16'h00A5, 10'h005);

    // Wait states, with branch/cu_ready wiggled while not valid
    stall = 1'b1;
    tick(); chk_fetch("ws.next", 10'h007);
    branch = 1'b1; pc_out = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_fetch("ws.hold", 10'h007);
    end
    stall = 1'b0; cu_ready = 1'b0; branch = 1'b0;
    tick(); chk_present("bp0", 16'h3C00, 16'h0000, 10'h007);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_present("bp.hold", 16'h3C00, 16'h0000, 10'h007);
    end

    // Wrap-around with immediate
    cu_ready = 1'b1; branch = 1'b1; pc_out = 10'h3FF;
    tick(); chk_fetch("wrap.fetch_i", 10'h3FF);
    branch = 1'b0;
    tick(); chk_fetch("wrap.fetch_m", 10'h000);
    tick(); chk_present("wrap.imm", 16'h0200, 16'h4834, 10'h3FF);
    tick(); chk_fetch("wrap.next", 10'h001);
    tick(); chk_present("wrap.after", 16'h6C12, 16'h0000, 10'h001);

    // Wrap-around without immediate
    mem[10'h3FF] = 16'h0001;
    branch = 1'b1; pc_out = 10'h3FF;
    tick(); chk_fetch("wrap2.fetch", 10'h3FF);
    branch = 1'b0;
    tick(); chk_present("wrap2", 16'h0001, 16'h0000, 10'h3FF);
    tick(); chk_fetch("wrap2.next", 10'h000);
    tick(); chk_present("wrap2.after", 16'h4834, 16'h0000, 10'h000);

    // Reset during FETCH_M with mem_valid high
    branch = 1'b1; pc_out = 10'h005;
    tick(); chk_fetch("mrst.fetch_i", 10'h005);
    branch = 1'b0;
    tick(); chk_fetch("mrst.fetch_m", 10'h006);
    chk("mrst.mem_valid", {31'd0, mem_valid}, 32'd1);
    rst_b = 1'b1;
    tick();
    chk("mrst.valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst.mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("mrst.mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("mrst.imm", {16'd0, imm}, 32'd0);
    chk("mrst.instr", {16'd0, instruction}, 32'd0);
    chk("mrst.pc", {22'd0, pc}, 32'd0);
    rst_b = 1'b0;
    tick(); chk_fetch("mrst.refetch", 10'h000);
    tick(); chk_present("mrst.after", 16'h4834, 16'h0000, 10'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
